// File: rtl/vote_capture.sv
// vote_capture: five-voter button front end. Each button is synchronized and
// debounced per lane; a timed session latches at most one vote per voter and
// presents the frozen ballot on comps once the session closes.

// Per-voter lane: 2-flop synchronizer, debouncer, one-cycle press pulse.
module vote_capture_lane #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic          s1, s2, db;
  logic [CW-1:0] cnt;

  // Two-stage synchronizer for the raw asynchronous button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Debounce: flip level after DEBOUNCE_CYCLES differing samples; a rising
  // flip emits a registered one-cycle press pulse, releases emit nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db    <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db    <= s2;
        cnt   <= '0;
        press <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module vote_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WINDOW_CYCLES   = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] vote_btn,
  input  logic       open_req,
  input  logic       close_req,
  input  logic       clear,
  output logic [4:0] comps,
  output logic       result_valid,
  output logic       session_open,
  output logic [2:0] votes_cast
);
  localparam int unsigned NUM_LANES = 5;
  localparam int unsigned WW        = $clog2(WINDOW_CYCLES);

  typedef enum logic [1:0] {IDLE, OPEN, CLOSED} state_t;

  state_t               state, nstate;
  logic [NUM_LANES-1:0] votes, nvotes, press;
  logic [WW-1:0]        win, nwin;

  function automatic logic [2:0] popcnt(input logic [NUM_LANES-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < NUM_LANES; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      vote_capture_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (vote_btn[g]),
        .press (press[g])
      );
    end
  endgenerate

  // Next-state, next ballot and window count; clear overrides everything.
  always_comb begin
    nstate = state;
    nvotes = votes;
    nwin   = win;
    case (state)
      IDLE: begin
        nvotes = '0;
        nwin   = '0;
        if (open_req) nstate = OPEN;
      end
      OPEN: begin
        // a press coincident with the close/timeout edge still counts
        nvotes = votes | press;
        nwin   = win + 1'b1;
        if (close_req || (win == WW'(WINDOW_CYCLES - 1))) nstate = CLOSED;
      end
      CLOSED: ;
      default: nstate = IDLE;
    endcase
    if (clear) begin
      nstate = IDLE;
      nvotes = '0;
      nwin   = '0;
    end
  end

  // State, ballot and all outputs registered from the next-state values so
  // the outputs change on the same edge as the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      votes        <= '0;
      win          <= '0;
      comps        <= '0;
      result_valid <= 1'b0;
      session_open <= 1'b0;
      votes_cast   <= '0;
    end else begin
      state        <= nstate;
      votes        <= nvotes;
      win          <= nwin;
      comps        <= (nstate == CLOSED) ? nvotes : '0;
      result_valid <= (nstate == CLOSED);
      session_open <= (nstate == OPEN);
      votes_cast   <= popcnt(nvotes);
    end
  end
endmodule
